fiapp_checker: RTL

Lockstep golden-model checker for the `fiapp` fault-injection target. It sits beside the DUT in the testbench and shares its clk/reset, and it mirrors the DUT stimulus (`a`, `enable`). It predicts `o1..o4` cycle by cycle and compares them with the DUT outputs. Each mismatch episode is logged into a small FIFO drained over a valid/ready handshake, so the injection harness can classify each injected fault as masked, latent or failure.

---
 rtl/fiapp_chk_pkg.sv | 45 ++++
 rtl/fiapp_checker_if.sv | 13 +
 rtl/fiapp_chk_fifo.sv | 74 +++++++
 rtl/fiapp_checker.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/fiapp_chk_pkg.sv
// Shared types and constants for the fiapp lockstep checker: FSM states,
// syndrome bit positions, model constants and the syndrome helper.
package fiapp_chk_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      FAULT = 2'd2
   } state_t;

   localparam int SYN_O1        = 0;
   localparam int SYN_O2        = 1;
   localparam int SYN_O3        = 2;
   localparam int SYN_O4        = 3;
   localparam int SYN_W         = 4;
   localparam int EXT_W         = 65;
   localparam int EXT_FORCE_BIT = 32;
   localparam int LOG_CYC_W     = 32;

   typedef struct packed {
      logic [LOG_CYC_W-1:0] cyc;
      logic [SYN_W-1:0]     syn;
   } log_entry_t;

   // One syndrome bit per DUT output; a set bit means observed != predicted.
   function automatic logic [SYN_W-1:0] calc_syn(
      input logic             obs1,
      input logic             exp1,
      input logic             obs2,
      input logic             exp2,
      input logic             obs3,
      input logic             exp3,
      input logic [EXT_W-1:0] obs4,
      input logic [EXT_W-1:0] exp4
   );
      logic [SYN_W-1:0] s;
      s         = 4'b0000;
      s[SYN_O1] = (obs1 != exp1);
      s[SYN_O2] = (obs2 != exp2);
      s[SYN_O3] = (obs3 != exp3);
      s[SYN_O4] = (obs4 != exp4);
      return s;
   endfunction

endpackage

// File: rtl/fiapp_checker_if.sv
// Fault-log drain channel: the checker presents the FIFO head, the harness
// accepts it with log_ready.
interface fiapp_checker_if #(
   parameter int CYC_W = 32
);
   logic             log_valid;
   logic             log_ready;
   logic [CYC_W-1:0] log_cycle;
   logic [3:0]       log_syn;

   modport master (output log_valid, output log_cycle, output log_syn, input log_ready);
   modport slave  (input log_valid, input log_cycle, input log_syn, output log_ready);
endinterface

// File: rtl/fiapp_chk_fifo.sv
// Synchronous FIFO with valid/ready head, full flag, synchronous clear and
// acceptance of a push when full if the head is popped in the same cycle.
module fiapp_chk_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 36
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         push,
   input  logic [W-1:0] push_data,
   output logic         valid,
   input  logic         ready,
   output logic [W-1:0] data,
   output logic         full
);
   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);

   logic [W-1:0]  mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   count_r;
   logic          pop_s;
   logic          wr_s;

   // Handshake decode; head data reads as zero when empty
   always_comb begin
      valid = (count_r != {(AW+1){1'b0}});
      full  = (count_r == CNT_FULL);
      pop_s = valid && ready;
      wr_s  = push && !clear && (!full || pop_s);
      if (valid) begin
         data = mem_r[rd_ptr_r];
      end else begin
         data = {W{1'b0}};
      end
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else if (clear) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else begin
         if (wr_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({wr_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage; when full with a pop, the slot being popped is reused
   always_ff @(posedge clk) begin
      if (wr_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

endmodule

// File: rtl/fiapp_checker.sv
// Lockstep golden model of fiapp: predicts o1..o4 every cycle, flags mismatches
// in a syndrome, and logs each new syndrome with its cycle stamp.
module fiapp_checker
   import fiapp_chk_pkg::*;
#(
   parameter int LOG_DEPTH = 4,
   parameter int CYC_W     = 32,
   parameter int CNT_W     = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               check_en,
   input  logic               clear,
   input  logic               a,
   input  logic               enable,
   input  logic               o1,
   input  logic               o2,
   input  logic               o3,
   input  logic [EXT_W-1:0]   o4,
   fiapp_checker_if.master    log_bus,
   output logic               err_sticky,
   output logic [CNT_W-1:0]   err_count,
   output logic [CNT_W-1:0]   drop_count,
   output state_t             state
);
   localparam int               ENTRY_W        = CYC_W + SYN_W;
   localparam logic [EXT_W-1:0] EXT_FORCE_MASK = 65'd1 << EXT_FORCE_BIT;
   localparam logic [CNT_W-1:0] CNT_MAX        = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1'b1);
   localparam logic [CYC_W-1:0] CYC_ONE        = CYC_W'(1'b1);

   logic               m_q1_r;
   logic               m_q2_r;
   logic               m_q3_r;
   logic [EXT_W-1:0]   m_ext_r;
   logic [CYC_W-1:0]   cyc_r;
   state_t             state_r;
   state_t             state_nxt_s;
   logic [SYN_W-1:0]   syn_s;
   logic [SYN_W-1:0]   syn_prev_r;
   logic               push_s;
   logic               pop_s;
   logic               drop_s;
   logic               fifo_full_s;
   logic               err_sticky_r;
   logic [CNT_W-1:0]   err_count_r;
   logic [CNT_W-1:0]   drop_count_r;
   logic [ENTRY_W-1:0] head_s;

   // Golden model of fiapp; runs regardless of check_en so it stays in lockstep
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_q1_r  <= 1'b0;
         m_q2_r  <= 1'b0;
         m_q3_r  <= 1'b0;
         m_ext_r <= {EXT_W{1'b0}};
      end else begin
         if (enable) begin
            m_q1_r <= a;
         end
         m_q2_r  <= m_q1_r;
         m_q3_r  <= ~m_q1_r;
         m_ext_r <= (m_ext_r + 65'd1) | EXT_FORCE_MASK;
      end
   end

   assign pop_s = log_bus.log_valid && log_bus.log_ready;

   // Syndrome and log push/drop decisions; a repeated identical syndrome logs once
   always_comb begin
      syn_s = 4'b0000;
      if (state_r == IDLE) begin
         syn_s = 4'b0000;
      end else begin
         syn_s = calc_syn(o1, m_q1_r, o2, m_q2_r, o3, m_q3_r & m_ext_r[EXT_W-1], o4, m_ext_r);
      end
      push_s = (syn_s != 4'b0000) && (syn_s != syn_prev_r) && !clear;
      drop_s = push_s && fifo_full_s && !pop_s;
   end

   // Next-state logic; dropping check_en wins over everything
   always_comb begin
      state_nxt_s = state_r;
      if (!check_en) begin
         state_nxt_s = IDLE;
      end else begin
         case (state_r)
            IDLE:    state_nxt_s = CHECK;
            CHECK:   state_nxt_s = (syn_s != 4'b0000) ? FAULT : CHECK;
            FAULT:   state_nxt_s = clear ? CHECK : FAULT;
            default: state_nxt_s = IDLE;
         endcase
      end
   end

   // State register and free-running timestamp (clear leaves the timestamp alone)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         cyc_r   <= {CYC_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         cyc_r   <= cyc_r + CYC_ONE;
      end
   end

   // Error bookkeeping: sticky flag, saturating counters, previous syndrome
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_sticky_r <= 1'b0;
         err_count_r  <= {CNT_W{1'b0}};
         drop_count_r <= {CNT_W{1'b0}};
         syn_prev_r   <= 4'b0000;
      end else if (clear) begin
         err_sticky_r <= 1'b0;
         err_count_r  <= {CNT_W{1'b0}};
         drop_count_r <= {CNT_W{1'b0}};
         syn_prev_r   <= 4'b0000;
      end else begin
         syn_prev_r <= syn_s;
         if (syn_s != 4'b0000) begin
            err_sticky_r <= 1'b1;
            if (err_count_r != CNT_MAX) begin
               err_count_r <= err_count_r + CNT_ONE;
            end
         end
         if (drop_s && (drop_count_r != CNT_MAX)) begin
            drop_count_r <= drop_count_r + CNT_ONE;
         end
      end
   end

   fiapp_chk_fifo #(
      .DEPTH (LOG_DEPTH),
      .W     (ENTRY_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .push      (push_s),
      .push_data ({cyc_r, syn_s}),
      .valid     (log_bus.log_valid),
      .ready     (log_bus.log_ready),
      .data      (head_s),
      .full      (fifo_full_s)
   );

   assign log_bus.log_cycle = head_s[ENTRY_W-1:SYN_W];
   assign log_bus.log_syn   = head_s[SYN_W-1:0];
   assign err_sticky        = err_sticky_r;
   assign err_count         = err_count_r;
   assign drop_count        = drop_count_r;
   assign state             = state_r;

endmodule
